// File: rtl/pu_column_loader_if.sv
// Groups the pixel-stream, PU write-port and round-control signals of one
// img2col PU front end. master = loader side, slave = environment side.
interface pu_column_loader_if #(
  parameter int unsigned data_width  = 16,
  parameter int unsigned address_num = 5,
  parameter int unsigned round_w     = 6
);
  logic                   en;
  logic [data_width-1:0]  s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   t_flag;
  logic [data_width-1:0]  new1;
  logic [address_num-1:0] adrs_in1;
  logic                   wr_ctrl_g;
  logic                   act;
  logic                   start;
  logic [round_w-1:0]     round;
  logic                   busy;
  logic                   done;

  modport master (
    input  en, s_data, s_valid, t_flag,
    output s_ready, new1, adrs_in1, wr_ctrl_g, act, start, round, busy, done
  );

  modport slave (
    output en, s_data, s_valid, t_flag,
    input  s_ready, new1, adrs_in1, wr_ctrl_g, act, start, round, busy, done
  );
endinterface

// File: rtl/pu_column_loader.sv
// Writer-side front end for one img2col PU: loads a full window in round 0,
// one column per later round, pulses start and waits for t_flag between rounds.
module pu_column_loader #(
  parameter int unsigned data_width  = 16,
  parameter int unsigned col_len     = 5,
  parameter int unsigned address_num = 5,
  parameter int unsigned round_w     = 6,
  parameter int unsigned num_rounds  = 28
) (
  input  logic                clk,
  input  logic                nrst,
  pu_column_loader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [address_num-1:0] win_last   = address_num'(col_len * col_len - 1);
  localparam logic [address_num-1:0] col_last   = address_num'(col_len - 1);
  localparam logic [round_w-1:0]     round_last = round_w'(num_rounds - 1);

  state_t                 state_q, state_d;
  logic [address_num-1:0] cnt_q, cnt_d;
  logic [round_w-1:0]     round_q, round_d;
  logic                   s_ready_q, s_ready_d;
  logic [data_width-1:0]  new1_q, new1_d;
  logic [address_num-1:0] adrs_q, adrs_d;
  logic                   wr_q, wr_d;
  logic                   act_q, act_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [address_num-1:0] last_idx;

  // Next-state and next-output logic; every output is registered below, so
  // each value computed here is what the PU sees in the following cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    s_ready_d = 1'b0;
    new1_d    = new1_q;
    adrs_d    = adrs_q;
    wr_d      = 1'b0;
    act_d     = act_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    last_idx  = (round_q == '0) ? win_last : col_last;

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d   = S_LOAD;
          round_d   = '0;
          cnt_d     = '0;
          act_d     = 1'b1;
          s_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        s_ready_d = 1'b1;
        if (bus.s_valid && s_ready_q) begin
          wr_d   = 1'b1;
          new1_d = bus.s_data;
          adrs_d = cnt_q;
          cnt_d  = cnt_q + 1'b1;
          // ready drops together with the final write so no extra beat slips in
          if (cnt_q == last_idx) begin
            state_d   = S_FIRE;
            s_ready_d = 1'b0;
          end
        end
      end
      S_FIRE: begin
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.t_flag) begin
          if (round_q == round_last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            act_d   = 1'b0;
          end else begin
            round_d   = round_q + 1'b1;
            cnt_d     = '0;
            state_d   = S_LOAD;
            s_ready_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; reset discards any partial column.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      s_ready_q <= 1'b0;
      new1_q    <= '0;
      adrs_q    <= '0;
      wr_q      <= 1'b0;
      act_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      s_ready_q <= s_ready_d;
      new1_q    <= new1_d;
      adrs_q    <= adrs_d;
      wr_q      <= wr_d;
      act_q     <= act_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.new1      = new1_q;
  assign bus.adrs_in1  = adrs_q;
  assign bus.wr_ctrl_g = wr_q;
  assign bus.act       = act_q;
  assign bus.start     = start_q;
  assign bus.round     = round_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pu_column_loader.sv
// Bench for pu_column_loader: table of rounds plus hand-written reset and
// ignored-input sequences; writes are checked through a scoreboard queue.
module tb_pu_column_loader;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  pu_column_loader_if #(.data_width(16), .address_num(5), .round_w(6)) bus ();

  pu_column_loader #(
    .data_width (16),
    .col_len    (5),
    .address_num(5),
    .round_w    (6),
    .num_rounds (3)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  adr;
    logic [15:0] dat;
  } wr_t;

  typedef struct {
    logic [15:0] base;      // first pixel value of the round
    int unsigned n;         // pixels expected to be written
    logic [3:0]  vpat;      // s_valid pattern, bit0 first
    logic [5:0]  exp_round; // round index expected during the round
    bit          last;      // t_flag must end the frame
    bit          tmid;      // inject t_flag during LOAD
    bit          enw;       // pulse en during WAIT
  } rec_t;

  rec_t tbl[3];
  wr_t  q[$];
  int   total = 0;
  int   bad = 0;
  int unsigned model_cnt = 0;
  int unsigned accepted = 0;
  int unsigned start_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned cyc = 0;
  int unsigned last_hs_cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop/compare writes, push the handshake about to happen.
  always @(negedge clk) begin
    if (nrst) begin
      q.delete();
    end else begin
      if (bus.wr_ctrl_g) begin
        if (q.size() == 0) begin
          chk("spurious_wr", 1'b1, 1'b0);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_adrs", 64'(bus.adrs_in1), 64'(e.adr));
          chk("wr_data", 64'(bus.new1), 64'(e.dat));
        end
      end
      if (bus.start) begin
        start_cnt++;
        // last handshake at edge k -> start registered at edge k+1
        chk("start_latency", 64'(cyc), 64'(last_hs_cyc + 1));
      end
      if (bus.done) done_cnt++;
      if (bus.s_valid && bus.s_ready) begin
        wr_t e;
        e.adr = 5'(model_cnt);
        e.dat = bus.s_data;
        q.push_back(e);
        model_cnt++;
        accepted++;
        last_hs_cyc = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {31'd0, bus.s_ready, bus.new1, bus.adrs_in1, bus.wr_ctrl_g, bus.act,
               bus.start, bus.round, bus.busy, bus.done}, 64'd0);
  endtask

  task automatic start_frame();
    model_cnt = 0;
    accepted  = 0;
    bus.en    = 1'b1;
    tick();
    bus.en    = 1'b0;
    chk("frame_act", bus.act, 1'b1);
    chk("frame_busy", bus.busy, 1'b1);
    chk("frame_round", 64'(bus.round), 64'd0);
    chk("frame_ready", bus.s_ready, 1'b1);
  endtask

  // Feed n pixels following the valid pattern; returns pixels accepted.
  task automatic feed(input rec_t r, input int unsigned n, output int unsigned got);
    int unsigned i = 0;
    int unsigned ph = 0;
    bit tsent = 0;
    bit hs;
    while (i < n && ph < 400) begin
      bus.s_valid = r.vpat[ph % 4];
      bus.s_data  = r.base + 16'(i);
      bus.t_flag  = r.tmid && (i == 2) && !tsent;
      if (bus.t_flag) tsent = 1;
      hs = bus.s_valid && bus.s_ready;
      tick();
      if (hs) i++;
      ph++;
    end
    bus.t_flag = 1'b0;
    got = i;
  endtask

  task automatic run_round(input rec_t r);
    int unsigned got;
    bit found = 0;
    model_cnt = 0;
    accepted  = 0;
    feed(r, r.n, got);
    chk("load_budget", 64'(got), 64'(r.n));
    // keep offering a pixel: it must not be taken
    bus.s_valid = 1'b1;
    bus.s_data  = 16'hDEAD;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bus.start) found = 1;
    end
    chk("start_seen", found, 1'b1);
    chk("round_idx", 64'(bus.round), 64'(r.exp_round));
    chk("accepted", 64'(accepted), 64'(r.n));
    bus.s_valid = 1'b0;
    if (r.enw) begin
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      for (int c = 0; c < 3; c++) begin
        chk("en_ignored", {bus.s_ready, bus.busy, bus.start, bus.round},
            {1'b0, 1'b1, 1'b0, r.exp_round});
        tick();
      end
    end
    bus.t_flag = 1'b1;
    tick();
    bus.t_flag = 1'b0;
    if (r.last) begin
      chk("done_pulse", {bus.done, bus.act, bus.busy}, {1'b1, 1'b0, 1'b1});
      tick();
      chk("after_done", {bus.done, bus.busy, bus.act}, 3'b000);
      chk("round_hold", 64'(bus.round), 64'(r.exp_round));
    end else begin
      chk("next_round", 64'(bus.round), 64'(r.exp_round + 6'd1));
      chk("next_ready", bus.s_ready, 1'b1);
    end
  endtask

  initial begin
    rec_t part;
    int unsigned got;

    tbl[0] = '{base: 16'd1,   n: 25, vpat: 4'b1111, exp_round: 6'd0, last: 0, tmid: 0, enw: 0};
    tbl[1] = '{base: 16'd100, n: 5,  vpat: 4'b1111, exp_round: 6'd1, last: 0, tmid: 1, enw: 1};
    tbl[2] = '{base: 16'd200, n: 5,  vpat: 4'b1001, exp_round: 6'd2, last: 1, tmid: 0, enw: 0};

    bus.en = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.t_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    nrst = 1'b0;
    tick();
    chk_all_zero("idle_state");

    // full three-round frame
    start_cnt = 0;
    done_cnt  = 0;
    start_frame();
    for (int r = 0; r < 3; r++) run_round(tbl[r]);
    chk("frame_starts", 64'(start_cnt), 64'd3);
    chk("frame_dones", 64'(done_cnt), 64'd1);

    // second frame, reset during round 2 after 3 of 5 pixels
    start_frame();
    run_round(tbl[0]);
    run_round(tbl[1]);
    part = tbl[2];
    part.vpat = 4'b1111;
    model_cnt = 0;
    accepted  = 0;
    feed(part, 3, got);
    chk("partial_fed", 64'(got), 64'd3);
    #2;
    nrst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    bus.s_valid = 1'b0;
    tick();
    chk_all_zero("reset_hold");
    nrst = 1'b0;
    tick();
    chk_all_zero("post_reset_idle");

    // restart is a full 25-pixel window in round 0
    start_cnt = 0;
    start_frame();
    run_round(tbl[0]);
    chk("restart_starts", 64'(start_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
